// File: rtl/ma_stage_if.sv
// ma_stage_if: the ma_stage port bundle. It holds the EX/MA handshake, the
// DM data-memory port and the MA/RW handshake.
//   master : the memory-access stage. It drives in_ready, dm_* and out_*.
//   slave  : the surrounding pipeline and memory. It drives in_*, dm_douta
//            and out_ready.
// N is the DM word-address width.
interface ma_stage_if #(
    parameter int N = 7
) ();
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_alu;
    logic [31:0] in_op2;
    logic [3:0]  in_rd;
    logic        in_isLd;
    logic        in_isSt;
    logic        in_isWb;

    logic         dm_ena;
    logic         dm_wea;
    logic [N-1:0] dm_addra;
    logic [31:0]  dm_dina;
    logic [31:0]  dm_douta;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_result;
    logic [3:0]  out_rd;
    logic        out_isWb;
    logic        out_fault;

    modport master (
        input  in_valid, in_pc, in_alu, in_op2, in_rd, in_isLd, in_isSt, in_isWb,
        output in_ready,
        output dm_ena, dm_wea, dm_addra, dm_dina,
        input  dm_douta,
        output out_valid, out_pc, out_result, out_rd, out_isWb, out_fault,
        input  out_ready
    );

    modport slave (
        output in_valid, in_pc, in_alu, in_op2, in_rd, in_isLd, in_isSt, in_isWb,
        input  in_ready,
        input  dm_ena, dm_wea, dm_addra, dm_dina,
        output dm_douta,
        input  out_valid, out_pc, out_result, out_rd, out_isWb, out_fault,
        output out_ready
    );
endinterface

// File: rtl/ma_stage.sv
// ma_stage: the memory-access pipeline stage. It sits between the EX/MA
// register and the RW stage and holds one entry.
// It drives the DM port in the same cycle that it accepts an entry. The DM
// read is registered inside DM, so load data reaches out_result one edge
// after accept, at the same time as out_valid.
// Ports:
//   clka, rstn         clock and async active-low reset
//   flush              drops the held entry and blocks accept this cycle
//   bus (master)       EX/MA handshake, DM port, MA/RW handshake
//   ld_count/st_count  counts of accepted non-faulting loads and stores
module ma_stage #(
    parameter int N  = 7,
    parameter int CW = 16
) (
    input  logic          clka,
    input  logic          rstn,
    input  logic          flush,
    ma_stage_if.master    bus,
    output logic [CW-1:0] ld_count,
    output logic [CW-1:0] st_count
);
    logic          out_valid_q, out_valid_d;
    logic [31:0]   out_pc_q,    out_pc_d;
    logic [31:0]   out_alu_q,   out_alu_d;
    logic [3:0]    out_rd_q,    out_rd_d;
    logic          out_isWb_q,  out_isWb_d;
    logic          out_isLd_q,  out_isLd_d;
    logic          out_fault_q, out_fault_d;
    logic [CW-1:0] ld_count_q,  ld_count_d;
    logic [CW-1:0] st_count_q,  st_count_d;

    logic in_ready;
    logic accept;
    logic is_mem;
    logic fault;

    // rstn is included so that the stage reads not-ready while reset is held.
    assign in_ready = rstn & ~flush & (~out_valid_q | bus.out_ready);
    assign accept   = bus.in_valid & in_ready;
    assign is_mem   = bus.in_isLd | bus.in_isSt;
    assign fault    = is_mem & (bus.in_alu[31:N] != '0);

    assign bus.in_ready = in_ready;
    assign bus.dm_ena   = accept & is_mem & ~fault;
    assign bus.dm_wea   = accept & is_mem & ~fault & bus.in_isSt;
    assign bus.dm_addra = bus.in_alu[N-1:0];
    assign bus.dm_dina  = bus.in_op2;

    always_comb begin
        out_valid_d = out_valid_q;
        out_pc_d    = out_pc_q;
        out_alu_d   = out_alu_q;
        out_rd_d    = out_rd_q;
        out_isWb_d  = out_isWb_q;
        out_isLd_d  = out_isLd_q;
        out_fault_d = out_fault_q;
        if (flush) begin
            // A flush wins over a drain in the same cycle. Accept is already
            // blocked through in_ready.
            out_valid_d = 1'b0;
        end else if (accept) begin
            out_valid_d = 1'b1;
            out_pc_d    = bus.in_pc;
            out_alu_d   = bus.in_alu;
            out_rd_d    = bus.in_rd;
            // If both ld and st are set, the entry is treated as a store.
            out_isLd_d  = bus.in_isLd & ~bus.in_isSt;
            out_isWb_d  = bus.in_isWb & ~fault;
            out_fault_d = fault;
        end else if (out_valid_q & bus.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_comb begin
        ld_count_d = ld_count_q + {{(CW-1){1'b0}},
                     accept & bus.in_isLd & ~bus.in_isSt & ~fault};
        st_count_d = st_count_q + {{(CW-1){1'b0}},
                     accept & bus.in_isSt & ~fault};
    end

    always_ff @(posedge clka or negedge rstn) begin
        if (!rstn) begin
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            out_alu_q   <= '0;
            out_rd_q    <= '0;
            out_isWb_q  <= 1'b0;
            out_isLd_q  <= 1'b0;
            out_fault_q <= 1'b0;
            ld_count_q  <= '0;
            st_count_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pc_q    <= out_pc_d;
            out_alu_q   <= out_alu_d;
            out_rd_q    <= out_rd_d;
            out_isWb_q  <= out_isWb_d;
            out_isLd_q  <= out_isLd_d;
            out_fault_q <= out_fault_d;
            ld_count_q  <= ld_count_d;
            st_count_q  <= st_count_d;
        end
    end

    // dm_douta is only valid for a load. DM holds its output while the stage
    // holds the entry, so this stays stable under backpressure.
    assign bus.out_result = (out_isLd_q & ~out_fault_q) ? bus.dm_douta : out_alu_q;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_pc     = out_pc_q;
    assign bus.out_rd     = out_rd_q;
    assign bus.out_isWb   = out_isWb_q;
    assign bus.out_fault  = out_fault_q;
    assign ld_count       = ld_count_q;
    assign st_count       = st_count_q;
endmodule

// File: tb/tb_ma_stage.sv
module tb_ma_stage;
    localparam int N  = 7;
    localparam int CW = 16;

    logic          clka = 1'b0;
    logic          rstn;
    logic          flush;
    logic [CW-1:0] ld_count, st_count;

    ma_stage_if #(.N(N)) bus ();

    ma_stage #(.N(N), .CW(CW)) dut (
        .clka     (clka),
        .rstn     (rstn),
        .flush    (flush),
        .bus      (bus),
        .ld_count (ld_count),
        .st_count (st_count)
    );

    always #5 clka = ~clka;

    // DM model: registered read with write-first behaviour. The output is
    // held while ena is low.
    logic [31:0] mem [0:(1<<N)-1];
    logic [31:0] dm_q = '0;
    always @(posedge clka) begin
        if (bus.dm_ena) begin
            if (bus.dm_wea) begin
                mem[bus.dm_addra] <= bus.dm_dina;
                dm_q <= bus.dm_dina;
            end else begin
                dm_q <= mem[bus.dm_addra];
            end
        end
    end
    assign bus.dm_douta = dm_q;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] res;
        logic [3:0]  rd;
        logic        wb;
        logic        f;
    } exp_t;
    exp_t sb[$];

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] res,
                        input logic [3:0] rd, input logic wb, input logic f);
        exp_t e;
        e.pc = pc; e.res = res; e.rd = rd; e.wb = wb; e.f = f;
        sb.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] alu,
                         input logic [31:0] op2, input logic [3:0] rd,
                         input logic ld, input logic st, input logic wb);
        bus.in_valid = v;
        bus.in_pc    = pc;
        bus.in_alu   = alu;
        bus.in_op2   = op2;
        bus.in_rd    = rd;
        bus.in_isLd  = ld;
        bus.in_isSt  = st;
        bus.in_isWb  = wb;
    endtask

    task automatic step();
        @(posedge clka);
        #1;
    endtask

    // Monitor: on each handshake it pops the oldest expected entry and compares.
    always @(negedge clka) begin
        if (rstn && bus.out_valid && bus.out_ready) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("FAIL mon_unexpected: got out_valid pc=%h expected no entry", bus.out_pc);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("mon_pc",     bus.out_pc,            e.pc);
                chk("mon_result", bus.out_result,        e.res);
                chk("mon_rd",     {28'd0, bus.out_rd},   {28'd0, e.rd});
                chk("mon_isWb",   {31'd0, bus.out_isWb}, {31'd0, e.wb});
                chk("mon_fault",  {31'd0, bus.out_fault},{31'd0, e.f});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected end of test");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0;
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        #3;
        chk("rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        chk("rst_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("rst_ld_count",  {16'd0, ld_count},      32'd0);
        chk("rst_st_count",  {16'd0, st_count},      32'd0);
        @(negedge clka);
        rstn = 1'b1;

        // store 5 <- DEADBEEF
        step();
        drive(1, 32'h100, 32'd5, 32'hDEADBEEF, 4'd0, 0, 1, 0);
        push(32'h100, 32'd5, 4'd0, 0, 0);
        @(negedge clka);
        chk("st_in_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("st_dm_ena",   {31'd0, bus.dm_ena},   32'd1);
        chk("st_dm_wea",   {31'd0, bus.dm_wea},   32'd1);
        chk("st_dm_addra", {25'd0, bus.dm_addra}, 32'd5);
        chk("st_dm_dina",  bus.dm_dina,           32'hDEADBEEF);

        // load 5 immediately after the store
        step();
        drive(1, 32'h104, 32'd5, 32'd0, 4'd3, 1, 0, 1);
        push(32'h104, 32'hDEADBEEF, 4'd3, 1, 0);
        @(negedge clka);
        chk("ld_dm_ena", {31'd0, bus.dm_ena}, 32'd1);
        chk("ld_dm_wea", {31'd0, bus.dm_wea}, 32'd0);

        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clka);
        chk("cnt1_st", {16'd0, st_count}, 32'd1);
        chk("cnt1_ld", {16'd0, ld_count}, 32'd1);

        // backpressure
        step();
        bus.out_ready = 1'b0;
        drive(1, 32'h108, 32'd5, 32'd0, 4'd4, 1, 0, 1);
        push(32'h108, 32'hDEADBEEF, 4'd4, 1, 0);
        @(negedge clka);
        chk("bp_accept", {31'd0, bus.in_ready}, 32'd1);
        for (int i = 0; i < 3; i++) begin
            step();
            drive(1, 32'h10C, 32'h1234, 32'd0, 4'd7, 0, 0, 1);
            @(negedge clka);
            chk("bp_in_ready",  {31'd0, bus.in_ready}, 32'd0);
            chk("bp_dm_ena",    {31'd0, bus.dm_ena},   32'd0);
            chk("bp_out_valid", {31'd0, bus.out_valid},32'd1);
            chk("bp_result",    bus.out_result,        32'hDEADBEEF);
        end
        step();
        bus.out_ready = 1'b1;
        push(32'h10C, 32'h1234, 4'd7, 1, 0);
        @(negedge clka);
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        chk("nm_dm_ena",        {31'd0, bus.dm_ena},   32'd0);

        // out-of-range load
        step();
        drive(1, 32'h110, 32'h80, 32'd0, 4'd2, 1, 0, 1);
        push(32'h110, 32'h80, 4'd2, 0, 1);
        @(negedge clka);
        chk("flt_dm_ena", {31'd0, bus.dm_ena}, 32'd0);
        chk("nm_ld_cnt",  {16'd0, ld_count},   32'd2);
        chk("nm_st_cnt",  {16'd0, st_count},   32'd1);

        // ld and st both set: handled as a store
        step();
        drive(1, 32'h114, 32'd9, 32'h55, 4'd5, 1, 1, 1);
        push(32'h114, 32'd9, 4'd5, 1, 0);
        @(negedge clka);
        chk("ldst_dm_ena", {31'd0, bus.dm_ena}, 32'd1);
        chk("ldst_dm_wea", {31'd0, bus.dm_wea}, 32'd1);
        chk("flt_ld_cnt",  {16'd0, ld_count},   32'd2);

        step();
        drive(1, 32'h118, 32'd9, 32'd0, 4'd1, 1, 0, 1);
        push(32'h118, 32'h55, 4'd1, 1, 0);
        @(negedge clka);
        chk("ldst_st_cnt", {16'd0, st_count}, 32'd2);
        chk("ldst_ld_cnt", {16'd0, ld_count}, 32'd2);

        // top in-range address
        step();
        drive(1, 32'h11C, 32'h7F, 32'hA5A50F0F, 4'd0, 0, 1, 0);
        push(32'h11C, 32'h7F, 4'd0, 0, 0);
        @(negedge clka);
        chk("top_dm_ena",   {31'd0, bus.dm_ena},   32'd1);
        chk("top_dm_addra", {25'd0, bus.dm_addra}, 32'h7F);
        chk("top_ld_cnt",   {16'd0, ld_count},     32'd3);

        step();
        drive(1, 32'h120, 32'h7F, 32'd0, 4'd8, 1, 0, 1);
        push(32'h120, 32'hA5A50F0F, 4'd8, 1, 0);

        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clka);
        chk("cnt2_ld", {16'd0, ld_count}, 32'd4);
        chk("cnt2_st", {16'd0, st_count}, 32'd3);

        // flush of a held entry while a load is offered
        step();
        bus.out_ready = 1'b0;
        drive(1, 32'h124, 32'h42, 32'd0, 4'd9, 0, 0, 1);
        @(negedge clka);
        chk("fl_pre_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        flush = 1'b1;
        drive(1, 32'h128, 32'd5, 32'd0, 4'd3, 1, 0, 1);
        @(negedge clka);
        chk("fl_in_ready", {31'd0, bus.in_ready},  32'd0);
        chk("fl_dm_ena",   {31'd0, bus.dm_ena},    32'd0);
        chk("fl_held",     {31'd0, bus.out_valid}, 32'd1);
        step();
        flush = 1'b0;
        bus.out_ready = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clka);
        chk("fl_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("fl_ld_cnt",    {16'd0, ld_count},      32'd4);

        // async reset between edges with an entry held
        step();
        bus.out_ready = 1'b0;
        drive(1, 32'h130, 32'd5, 32'd0, 4'd6, 1, 0, 1);
        @(negedge clka);
        chk("ar_pre_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        chk("ar_pre_ld", {16'd0, ld_count},      32'd5);
        chk("ar_pre_ov", {31'd0, bus.out_valid}, 32'd1);
        #1;
        rstn = 1'b0;
        #1;
        chk("ar_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("ar_ld_cnt",    {16'd0, ld_count},      32'd0);
        chk("ar_st_cnt",    {16'd0, st_count},      32'd0);
        chk("ar_out_pc",    bus.out_pc,             32'd0);
        chk("ar_result",    bus.out_result,         32'd0);
        chk("ar_rd",        {28'd0, bus.out_rd},    32'd0);
        chk("ar_isWb",      {31'd0, bus.out_isWb},  32'd0);
        chk("ar_fault",     {31'd0, bus.out_fault}, 32'd0);
        chk("ar_in_ready",  {31'd0, bus.in_ready},  32'd0);
        step();
        chk("ar_hold_ready", {31'd0, bus.in_ready}, 32'd0);
        @(negedge clka);
        rstn = 1'b1;
        #1;
        chk("ar_rel_ready", {31'd0, bus.in_ready}, 32'd1);

        // DM contents survive the stage reset
        bus.out_ready = 1'b1;
        step();
        drive(1, 32'h140, 32'd5, 32'd0, 4'd10, 1, 0, 1);
        push(32'h140, 32'hDEADBEEF, 4'd10, 1, 0);
        step();
        drive(0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clka);
        chk("post_ld_cnt", {16'd0, ld_count}, 32'd1);
        step();
        step();
        chk("sb_drained", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
